// File: rtl/usb_link_sequencer.sv
// USB link-layer transaction sequencer: tracks token/data/handshake phases in master or
// slave mode, inserts bus turnaround, enforces response timeout and bounded retries.
module usb_link_sequencer #(
  parameter int unsigned TW        = 16,
  parameter int unsigned DW        = 6,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned RW        = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ms,
  input  logic          rx_pid_en,
  input  logic [3:0]    rx_pid,
  input  logic          rx_sop_en,
  input  logic          rx_lt_eop_en,
  input  logic          tx_con_pid_en,
  input  logic [3:0]    tx_con_pid,
  input  logic          tx_lp_eop_en,
  input  logic [TW-1:0] time_threshold,
  input  logic [DW-1:0] delay_threshold,
  output logic          rx_data_on,
  output logic          rx_handshake_on,
  output logic          tx_data_on,
  output logic          d_oe,
  output logic          time_out,
  output logic          retry_req,
  output logic          xfer_done,
  output logic          xfer_err,
  output logic [1:0]    err_code,
  output logic [RW-1:0] retry_cnt
);

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  typedef enum logic [2:0] {
    S_IDLE, S_TOKEN, S_TURN, S_TX_DATA, S_WAIT_DATA, S_WAIT_HS, S_TX_HS
  } state_t;

  state_t        state_q, state_nxt, turn_next_q, turn_next_nxt;
  logic          ms_q, ms_nxt, tok_in_q, tok_in_nxt;
  logic [TW-1:0] timer_q, timer_nxt;
  logic          sop_seen_q, sop_seen_nxt;
  logic [DW-1:0] dly_q, dly_nxt;
  logic          d_oe_q, d_oe_nxt;
  logic          time_out_nxt, retry_req_nxt, xfer_done_nxt, xfer_err_nxt;
  logic [1:0]    err_code_nxt;
  logic [RW-1:0] retry_cnt_nxt;
  logic          in_wait, timeout_c;

  function automatic logic is_token(input logic [3:0] pid);
    return (pid == PID_OUT) || (pid == PID_IN) || (pid == PID_SETUP);
  endfunction

  // Bus direction follows ms live while idle, otherwise the registered value
  assign d_oe = (state_q == S_IDLE) ? ms : d_oe_q;

  assign in_wait   = (state_q == S_WAIT_DATA) || (state_q == S_WAIT_HS);
  assign timeout_c = in_wait && (timer_q == time_threshold) && !rx_pid_en && !rx_sop_en
                     && !sop_seen_q;

  // Next-state and status decode
  always_comb begin
    state_nxt     = state_q;
    turn_next_nxt = turn_next_q;
    ms_nxt        = ms_q;
    tok_in_nxt    = tok_in_q;
    time_out_nxt  = 1'b0;
    retry_req_nxt = 1'b0;
    xfer_done_nxt = 1'b0;
    xfer_err_nxt  = 1'b0;
    err_code_nxt  = err_code;
    retry_cnt_nxt = retry_cnt;

    case (state_q)
      S_IDLE: begin
        if (ms && tx_con_pid_en && is_token(tx_con_pid)) begin
          state_nxt  = S_TOKEN;
          ms_nxt     = 1'b1;
          tok_in_nxt = (tx_con_pid == PID_IN);
        end else if (!ms && rx_pid_en && is_token(rx_pid)) begin
          ms_nxt = 1'b0;
          if (rx_pid == PID_IN) begin
            state_nxt     = S_TURN;
            turn_next_nxt = S_TX_DATA;
          end else begin
            state_nxt = S_WAIT_DATA;
          end
        end
      end
      S_TOKEN: begin
        if (tx_lp_eop_en) begin
          if (tok_in_q) begin
            state_nxt     = S_TURN;
            turn_next_nxt = S_WAIT_DATA;
          end else begin
            state_nxt = S_TX_DATA;
          end
        end
      end
      S_TURN: begin
        if (dly_q == delay_threshold) state_nxt = turn_next_q;
      end
      S_TX_DATA: begin
        if (tx_lp_eop_en) begin
          state_nxt     = S_TURN;
          turn_next_nxt = S_WAIT_HS;
        end
      end
      S_WAIT_DATA: begin
        if (rx_lt_eop_en) begin
          state_nxt     = S_TURN;
          turn_next_nxt = S_TX_HS;
        end
      end
      S_WAIT_HS: begin
        if (rx_pid_en) begin
          if (rx_pid == PID_ACK) begin
            state_nxt     = S_IDLE;
            xfer_done_nxt = 1'b1;
          end else if (rx_pid == PID_NAK && ms_q) begin
            state_nxt     = S_IDLE;
            retry_req_nxt = 1'b1;
          end else if (rx_pid == PID_NAK || rx_pid == PID_STALL) begin
            state_nxt    = S_IDLE;
            xfer_err_nxt = 1'b1;
            err_code_nxt = 2'd2;
          end
        end
      end
      S_TX_HS: begin
        if (tx_lp_eop_en) begin
          state_nxt     = S_IDLE;
          xfer_done_nxt = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    // Timeout only when no received event claimed this cycle
    if (timeout_c && state_nxt == state_q) begin
      state_nxt    = S_IDLE;
      time_out_nxt = 1'b1;
      if (!ms_q) begin
        xfer_err_nxt = 1'b1;
        err_code_nxt = 2'd1;
      end else if (retry_cnt < RW'(MAX_RETRY)) begin
        retry_req_nxt = 1'b1;
        retry_cnt_nxt = retry_cnt + RW'(1);
      end else begin
        xfer_err_nxt  = 1'b1;
        err_code_nxt  = 2'd3;
        retry_cnt_nxt = '0;
      end
    end

    if (xfer_done_nxt) begin
      err_code_nxt  = 2'd0;
      retry_cnt_nxt = '0;
    end
  end

  // Timer, turnaround counter and direction next values
  always_comb begin
    timer_nxt    = timer_q;
    sop_seen_nxt = 1'b0;
    dly_nxt      = dly_q;
    d_oe_nxt     = 1'b0;

    if ((state_nxt == S_WAIT_DATA || state_nxt == S_WAIT_HS) && state_nxt != state_q) begin
      timer_nxt = '0;
    end else if (in_wait) begin
      sop_seen_nxt = sop_seen_q || (state_q == S_WAIT_DATA && rx_sop_en);
      timer_nxt    = sop_seen_nxt ? '0 : timer_q + TW'(1);
    end

    if (state_nxt == S_TURN && state_q != S_TURN) dly_nxt = '0;
    else if (state_q == S_TURN)                   dly_nxt = dly_q + DW'(1);

    case (state_nxt)
      S_TOKEN, S_TX_DATA, S_TX_HS: d_oe_nxt = 1'b1;
      S_TURN:                      d_oe_nxt = d_oe;
      default:                     d_oe_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      turn_next_q     <= S_IDLE;
      ms_q            <= 1'b0;
      tok_in_q        <= 1'b0;
      timer_q         <= '0;
      sop_seen_q      <= 1'b0;
      dly_q           <= '0;
      d_oe_q          <= 1'b0;
      rx_data_on      <= 1'b0;
      rx_handshake_on <= 1'b0;
      tx_data_on      <= 1'b0;
      time_out        <= 1'b0;
      retry_req       <= 1'b0;
      xfer_done       <= 1'b0;
      xfer_err        <= 1'b0;
      err_code        <= 2'd0;
      retry_cnt       <= '0;
    end else begin
      state_q         <= state_nxt;
      turn_next_q     <= turn_next_nxt;
      ms_q            <= ms_nxt;
      tok_in_q        <= tok_in_nxt;
      timer_q         <= timer_nxt;
      sop_seen_q      <= sop_seen_nxt;
      dly_q           <= dly_nxt;
      d_oe_q          <= d_oe_nxt;
      rx_data_on      <= (state_nxt == S_WAIT_DATA);
      rx_handshake_on <= (state_nxt == S_WAIT_HS);
      tx_data_on      <= (state_nxt == S_TX_DATA);
      time_out        <= time_out_nxt;
      retry_req       <= retry_req_nxt;
      xfer_done       <= xfer_done_nxt;
      xfer_err        <= xfer_err_nxt;
      err_code        <= err_code_nxt;
      retry_cnt       <= retry_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_usb_link_sequencer.sv
// Scoreboard bench for usb_link_sequencer: expected status pulses are queued when the
// stimulus is driven and matched whenever the DUT raises a pulse.
module tb_usb_link_sequencer;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  logic        clk = 1'b0;
  logic        rst_n, ms;
  logic        rx_pid_en, rx_sop_en, rx_lt_eop_en, tx_con_pid_en, tx_lp_eop_en;
  logic [3:0]  rx_pid, tx_con_pid;
  logic [15:0] time_threshold;
  logic [5:0]  delay_threshold;
  logic        rx_data_on, rx_handshake_on, tx_data_on, d_oe;
  logic        time_out, retry_req, xfer_done, xfer_err;
  logic [1:0]  err_code, retry_cnt;

  int checks = 0;
  int failures = 0;
  logic [7:0] sb_q[$];

  usb_link_sequencer dut (
    .clk(clk), .rst_n(rst_n), .ms(ms),
    .rx_pid_en(rx_pid_en), .rx_pid(rx_pid), .rx_sop_en(rx_sop_en),
    .rx_lt_eop_en(rx_lt_eop_en), .tx_con_pid_en(tx_con_pid_en), .tx_con_pid(tx_con_pid),
    .tx_lp_eop_en(tx_lp_eop_en), .time_threshold(time_threshold),
    .delay_threshold(delay_threshold), .rx_data_on(rx_data_on),
    .rx_handshake_on(rx_handshake_on), .tx_data_on(tx_data_on), .d_oe(d_oe),
    .time_out(time_out), .retry_req(retry_req), .xfer_done(xfer_done),
    .xfer_err(xfer_err), .err_code(err_code), .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Status word: {done, err, retry, tout, err_code, retry_cnt}
  task automatic push(input logic done, input logic err, input logic retry, input logic tout,
                      input logic [1:0] code, input logic [1:0] cnt);
    sb_q.push_back({done, err, retry, tout, code, cnt});
  endtask

  always @(negedge clk) begin
    if (rst_n && (xfer_done || xfer_err || retry_req || time_out)) begin
      if (sb_q.size() == 0)
        chk("unexpected_pulse", {xfer_done, xfer_err, retry_req, time_out}, 4'b0);
      else
        chk("status", {xfer_done, xfer_err, retry_req, time_out, err_code, retry_cnt},
            sb_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tx_con(input logic [3:0] pid);
    tx_con_pid = pid; tx_con_pid_en = 1'b1; tick(); tx_con_pid_en = 1'b0;
  endtask
  task automatic pulse_rx_pid(input logic [3:0] pid);
    rx_pid = pid; rx_pid_en = 1'b1; tick(); rx_pid_en = 1'b0;
  endtask
  task automatic pulse_tx_eop();
    tx_lp_eop_en = 1'b1; tick(); tx_lp_eop_en = 1'b0;
  endtask
  task automatic pulse_rx_eop();
    rx_lt_eop_en = 1'b1; tick(); rx_lt_eop_en = 1'b0;
  endtask
  task automatic pulse_sop();
    rx_sop_en = 1'b1; tick(); rx_sop_en = 1'b0;
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return rx_data_on;
      1:       return rx_handshake_on;
      2:       return tx_data_on;
      default: return time_out;
    endcase
  endfunction

  // Bounded wait for a DUT output; n returns the cycles taken
  task automatic wait_sig(input string tag, input int sel, output int n);
    n = 0;
    while (!sig(sel) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk(tag, 0, 1);
  endtask

  task automatic master_out_to_hs(output int n);
    pulse_tx_con(PID_OUT);
    pulse_tx_eop();
    pulse_tx_eop();
    wait_sig("wait_hs", 1, n);
  endtask

  task automatic master_in_timeout(input int i, input logic last);
    int n;
    pulse_tx_con(PID_IN);
    pulse_tx_eop();
    wait_sig("wait_data", 0, n);
    chk("wait_doe", d_oe, 0);
    push(1'b0, last, !last, 1'b1, last ? 2'd3 : 2'd0, last ? 2'd0 : 2'(i + 1));
    wait_sig("wait_tout", 3, n);
    chk("tout_latency", n, 11);
  endtask

  initial begin
    int n, touts;
    rst_n = 1'b0; ms = 1'b1;
    rx_pid_en = 0; rx_sop_en = 0; rx_lt_eop_en = 0; tx_con_pid_en = 0; tx_lp_eop_en = 0;
    rx_pid = '0; tx_con_pid = '0;
    time_threshold = 16'd20; delay_threshold = 6'd3;

    tick();
    chk("rst_pulses", {xfer_done, xfer_err, retry_req, time_out}, 4'b0);
    chk("rst_enables", {rx_data_on, rx_handshake_on, tx_data_on}, 3'b0);
    chk("rst_code_cnt", {err_code, retry_cnt}, 4'b0);
    chk("rst_doe_ms1", d_oe, 1);
    ms = 1'b0; #1;
    chk("rst_doe_ms0", d_oe, 0);
    ms = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Master OUT with 4-cycle turnaround, ACK
    pulse_tx_con(PID_OUT);
    chk("token_doe", d_oe, 1);
    pulse_tx_eop();
    chk("txdata_on", tx_data_on, 1);
    chk("txdata_doe", d_oe, 1);
    pulse_tx_eop();
    chk("turn_doe", d_oe, 1);
    wait_sig("wait_hs", 1, n);
    chk("turn_len", n, 4);
    chk("hs_doe", d_oe, 0);
    push(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    pulse_rx_pid(PID_ACK);
    chk("hs_off", rx_handshake_on, 0);

    // Master IN, no response: three retries then giving up
    time_threshold = 16'd10; delay_threshold = 6'd0;
    for (int i = 0; i < 4; i++) master_in_timeout(i, i == 3);
    tick();
    chk("give_up_cnt", retry_cnt, 0);

    // Master OUT NAK then ACK; err_code holds 3 across the NAK
    master_out_to_hs(n);
    push(1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 2'd0);
    pulse_rx_pid(PID_NAK);
    master_out_to_hs(n);
    push(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    pulse_rx_pid(PID_ACK);

    // ACK exactly at timer == threshold wins over the timeout, and clears retry_cnt
    master_in_timeout(0, 1'b0);
    master_out_to_hs(n);
    repeat (10) tick();
    push(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    pulse_rx_pid(PID_ACK);
    tick();

    // Slave IN answered STALL
    ms = 1'b0;
    pulse_rx_pid(PID_IN);
    wait_sig("sl_txdata", 2, n);
    pulse_tx_eop();
    wait_sig("sl_hs", 1, n);
    push(1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 2'd0);
    pulse_rx_pid(PID_STALL);

    // Slave IN, ms raised mid-transaction, NAK still a slave error
    pulse_rx_pid(PID_IN);
    wait_sig("sl_txdata2", 2, n);
    ms = 1'b1;
    pulse_tx_eop();
    wait_sig("sl_hs2", 1, n);
    push(1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 2'd0);
    pulse_rx_pid(PID_NAK);
    ms = 1'b0;
    tick();

    // Slave OUT, long packet after rx_sop_en never times out
    time_threshold = 16'd8;
    pulse_rx_pid(PID_OUT);
    chk("sl_rxdata_on", rx_data_on, 1);
    repeat (5) tick();
    pulse_sop();
    touts = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (time_out) touts++;
    end
    chk("sop_no_tout", touts, 0);
    pulse_rx_eop();
    tick();
    chk("txhs_doe", d_oe, 1);
    push(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    pulse_tx_eop();

    // Slave OUT, no data: slave timeout, no retry
    pulse_rx_pid(PID_OUT);
    push(1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 2'd0);
    wait_sig("sl_tout", 3, n);
    chk("sl_tout_latency", n, 9);
    tick();

    // Reset during WAIT_HS
    ms = 1'b1; time_threshold = 16'd50;
    master_out_to_hs(n);
    rst_n = 1'b0; #1;
    chk("mid_rst_pulses", {xfer_done, xfer_err, retry_req, time_out}, 4'b0);
    chk("mid_rst_enables", {rx_data_on, rx_handshake_on, tx_data_on}, 3'b0);
    chk("mid_rst_code", err_code, 0);
    chk("mid_rst_doe1", d_oe, 1);
    ms = 1'b0; #1;
    chk("mid_rst_doe0", d_oe, 0);
    tick(); tick();
    rst_n = 1'b1;
    repeat (3) tick();

    chk("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
